// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
//   Shares the byte-serial memory controller between the IF stage
//   (instruction fetch) and the MEM stage (load/store). Accepts one request
//   at a time, issues it to the controller with a one-cycle start strobe,
//   waits for completion and returns the response to the owning stage.
//   MEM has fixed priority over IF.
//
//   Optional build macro: MEM_ARB_FAIRNESS_EN
//     Adds a streak counter so that after STREAK_MAX consecutive MEM grants
//     taken while IF was waiting, IF gets the next grant.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr/if_len    IF fetch request; if_gnt accepts it (comb.)
//   if_flush                 kill the current or pending IF fetch response
//   if_rvalid                one-cycle IF response strobe
//   mem_req/we/addr/len/wdata MEM load/store request; mem_gnt accepts (comb.)
//   mem_rvalid               one-cycle MEM completion strobe
//   rdata                    response data, valid with either rvalid
//   ctrl_start/we/addr/len/wdata  command to the controller
//   ctrl_busy/done/rdata     controller status and read data
//   busy                     arbiter is not idle
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int STREAK_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic [2:0]            if_len,
   output logic                  if_gnt,
   input  logic                  if_flush,
   output logic                  if_rvalid,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [2:0]            mem_len,
   input  logic [31:0]           mem_wdata,
   output logic                  mem_gnt,
   output logic                  mem_rvalid,
   output logic [31:0]           rdata,
   output logic                  ctrl_start,
   output logic                  ctrl_we,
   output logic [ADDR_WIDTH-1:0] ctrl_addr,
   output logic [2:0]            ctrl_len,
   output logic [31:0]           ctrl_wdata,
   input  logic                  ctrl_busy,
   input  logic                  ctrl_done,
   input  logic [31:0]           ctrl_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                state_q;
   logic                  owner_mem_q;   // 0 = IF owns the transaction, 1 = MEM
   logic                  kill_q;        // IF response of this transaction is stale
   logic                  ctrl_we_q;
   logic [ADDR_WIDTH-1:0] ctrl_addr_q;
   logic [2:0]            ctrl_len_q;
   logic [31:0]           ctrl_wdata_q;
   logic [31:0]           rdata_q;

   logic                  idle;
   logic                  force_if;
   logic [2:0]            req_len;
   logic [2:0]            acc_len;

   assign idle = (state_q == IDLE);

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

   logic [SW-1:0] streak_q;

   // Streak exhausted and both stages asking: hand this slot to IF.
   assign force_if = (streak_q == SW'(STREAK_MAX)) && if_req && !if_flush && mem_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_q <= '0;
      end else if (idle) begin
         if (if_gnt || !if_req)
            streak_q <= '0;
         else if (mem_gnt && !if_flush)
            streak_q <= streak_q + SW'(1);
      end
   end
`else
   assign force_if = 1'b0;

   // The streak limit has no effect without the fairness guard.
   logic unused_streak_max;
   assign unused_streak_max = (STREAK_MAX != 0);
`endif

   assign mem_gnt = idle && mem_req && !force_if;
   assign if_gnt  = idle && if_req && !if_flush && !mem_gnt;

   // Controller transfers at most 4 bytes; longer requests are clamped.
   always_comb begin
      req_len = mem_gnt ? mem_len : if_len;
      acc_len = (req_len > 3'd4) ? 3'd4 : req_len;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_mem_q  <= 1'b0;
         kill_q       <= 1'b0;
         ctrl_we_q    <= 1'b0;
         ctrl_addr_q  <= '0;
         ctrl_len_q   <= 3'd0;
         ctrl_wdata_q <= 32'd0;
         rdata_q      <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mem_gnt || if_gnt) begin
                  owner_mem_q  <= mem_gnt;
                  kill_q       <= 1'b0;
                  ctrl_we_q    <= mem_gnt && mem_we;
                  ctrl_addr_q  <= mem_gnt ? mem_addr : if_addr;
                  ctrl_len_q   <= acc_len;
                  ctrl_wdata_q <= mem_gnt ? mem_wdata : 32'd0;
                  // Zero-length requests complete without touching the controller.
                  if (acc_len == 3'd0) begin
                     rdata_q <= 32'd0;
                     state_q <= RESP;
                  end else begin
                     state_q <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (if_flush && !owner_mem_q)
                  kill_q <= 1'b1;
               if (!ctrl_busy)
                  state_q <= WAIT;
            end
            WAIT: begin
               if (if_flush && !owner_mem_q)
                  kill_q <= 1'b1;
               if (ctrl_done) begin
                  rdata_q <= ctrl_we_q ? 32'd0 : ctrl_rdata;
                  state_q <= RESP;
               end
            end
            RESP: begin
               // A flush arriving now is handled combinationally on if_rvalid.
               kill_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Start fires in the first ISSUE cycle the controller is free.
   assign ctrl_start = (state_q == ISSUE) && !ctrl_busy;
   assign if_rvalid  = (state_q == RESP) && !owner_mem_q && !kill_q && !if_flush;
   assign mem_rvalid = (state_q == RESP) && owner_mem_q;
   assign busy       = !idle;

   assign ctrl_we    = ctrl_we_q;
   assign ctrl_addr  = ctrl_addr_q;
   assign ctrl_len   = ctrl_len_q;
   assign ctrl_wdata = ctrl_wdata_q;
   assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_flush, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [2:0]    if_len;
   logic          mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [2:0]    mem_len;
   logic [31:0]   mem_wdata;
   logic [31:0]   rdata;
   logic          ctrl_start, ctrl_we, ctrl_busy, ctrl_done;
   logic [AW-1:0] ctrl_addr;
   logic [2:0]    ctrl_len;
   logic [31:0]   ctrl_wdata, ctrl_rdata;
   logic          busy;
   logic          ctrl_done_m, spur_done;

   int            n_checks = 0;
   int            n_errors = 0;
   int            ctl_lat = 1;
   logic [31:0]   ctl_data = 32'd0;
   int            start_cnt = 0;

   assign ctrl_done = ctrl_done_m | spur_done;

   mem_arbiter #(.ADDR_WIDTH(AW), .STREAK_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_len(if_len), .if_gnt(if_gnt),
      .if_flush(if_flush), .if_rvalid(if_rvalid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .rdata(rdata),
      .ctrl_start(ctrl_start), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
      .ctrl_len(ctrl_len), .ctrl_wdata(ctrl_wdata),
      .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Controller model: answers each start after ctl_lat cycles with ctl_data.
   initial begin
      ctrl_done_m = 1'b0;
      ctrl_rdata  = 32'h0BAD_F00D;
      forever begin
         @(negedge clk);
         if (ctrl_start === 1'b1) begin
            start_cnt++;
            repeat (ctl_lat) @(posedge clk);
            #1 ctrl_done_m = 1'b1;
            ctrl_rdata = ctl_data;
            @(posedge clk);
            #1 ctrl_done_m = 1'b0;
            ctrl_rdata = $urandom;
         end
      end
   end

   // Present a request for one cycle (IF kept requesting when both=1) and
   // check which side is granted. Returns 1ns after the accepting edge.
   task automatic issue(input bit m, input bit we, input logic [31:0] a,
                        input logic [2:0] l, input logic [31:0] wd, input bit both);
      if (m) begin
         mem_req = 1'b1; mem_we = we; mem_addr = a; mem_len = l; mem_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = a; if_len = l;
      end
      if (both) if_req = 1'b1;
      @(negedge clk);
      chk("mem_gnt", mem_gnt, m);
      chk("if_gnt", if_gnt, !m);
      @(posedge clk); #1;
      mem_req = 1'b0;
      if (!both) if_req = 1'b0;
   endtask

   // Follow an accepted transaction to IDLE against the reference rules.
   // fl: 0 none, 1 flush one cycle after start, 2 flush in the response cycle.
   task automatic complete(input bit m, input bit we, input logic [31:0] a,
                           input logic [2:0] l, input logic [31:0] wd,
                           input logic [31:0] rd, input int lat, input int bcyc,
                           input int fl, input bit exp_if_next);
      logic [2:0]  e_len;
      logic [31:0] e_rd, rv_data;
      int          e_cyc, cyc, st0, rv_cyc, wrong_rv;
      bit          fin;
      e_len    = (l > 3'd4) ? 3'd4 : l;
      e_rd     = (l == 3'd0 || (m && we)) ? 32'd0 : rd;
      e_cyc    = (l == 3'd0) ? 1 : 2 + bcyc + lat;
      ctl_lat  = lat;
      ctl_data = rd;
      ctrl_busy = (bcyc > 0);
      st0 = start_cnt; cyc = 0; rv_cyc = -1; wrong_rv = 0; rv_data = 32'd0; fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         if (ctrl_start === 1'b1) begin
            chk("start_cycle", cyc, bcyc + 1);
            chk("ctrl_addr", ctrl_addr, a);
            chk("ctrl_len", ctrl_len, e_len);
            chk("ctrl_we", ctrl_we, m && we);
            if (m && we) chk("ctrl_wdata", ctrl_wdata, wd);
         end
         if ((m ? mem_rvalid : if_rvalid) === 1'b1) begin
            rv_cyc = cyc; rv_data = rdata;
         end
         if ((m ? if_rvalid : mem_rvalid) === 1'b1) wrong_rv++;
         if (busy === 1'b0 || cyc > 200) begin
            fin = 1'b1;
         end else begin
            @(posedge clk); #1;
            ctrl_busy = (cyc < bcyc);
            if_flush  = (fl == 1 && cyc == bcyc + 1) || (fl == 2 && cyc == e_cyc - 1);
         end
      end
      if_flush = 1'b0;
      chk("busy_cycles", cyc, e_cyc + 1);
      chk("rvalid_cycle", rv_cyc, (fl != 0 && !m) ? -1 : e_cyc);
      if (rv_cyc >= 0) chk("rdata", rv_data, e_rd);
      chk("wrong_rvalid", wrong_rv, 0);
      chk("start_count", start_cnt - st0, (l == 3'd0) ? 0 : 1);
      if (exp_if_next) begin
         chk("if_gnt_after", if_gnt, 1'b1);
         chk("mem_gnt_after", mem_gnt, 1'b0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bit          m, we;
      logic [31:0] a, wd, rd;
      logic [2:0]  l;
      int          lat, bcyc, fl, st0, ng;
      bit          got_if[$];
      bit          exp_if;

      rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0; if_len = 3'd0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_len = 3'd0; mem_wdata = 32'd0;
      ctrl_busy = 1'b0; spur_done = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ctrl_start", ctrl_start, 1'b0);
      chk("rst_ctrl_addr", ctrl_addr, 32'd0);
      chk("rst_ctrl_len", ctrl_len, 3'd0);
      chk("rst_ctrl_we", ctrl_we, 1'b0);
      chk("rst_ctrl_wdata", ctrl_wdata, 32'd0);
      chk("rst_if_rvalid", if_rvalid, 1'b0);
      chk("rst_mem_rvalid", mem_rvalid, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // IF fetch, 6-cycle controller latency
      issue(1'b0, 1'b0, 32'h100, 3'd4, 32'd0, 1'b0);
      complete(1'b0, 1'b0, 32'h100, 3'd4, 32'd0, 32'hDEADBEEF, 6, 0, 0, 1'b0);

      // MEM store beats simultaneous IF; IF granted in the first IDLE cycle after
      if_addr = 32'h200; if_len = 3'd4;
      issue(1'b1, 1'b1, 32'h20, 3'd2, 32'h1234, 1'b1);
      complete(1'b1, 1'b1, 32'h20, 3'd2, 32'h1234, 32'h5555AAAA, 3, 0, 0, 1'b1);
      if_req = 1'b0;
      complete(1'b0, 1'b0, 32'h200, 3'd4, 32'd0, 32'hCAFEF00D, 2, 0, 0, 1'b0);

      // Flush in WAIT drops the fetch response; following MEM load is normal
      issue(1'b0, 1'b0, 32'h300, 3'd3, 32'd0, 1'b0);
      complete(1'b0, 1'b0, 32'h300, 3'd3, 32'd0, 32'h01020304, 4, 0, 1, 1'b0);
      issue(1'b1, 1'b0, 32'h40, 3'd4, 32'd0, 1'b0);
      complete(1'b1, 1'b0, 32'h40, 3'd4, 32'd0, 32'h11223344, 3, 0, 0, 1'b0);

      // Flush in the response cycle; flush during a MEM response has no effect
      issue(1'b0, 1'b0, 32'h304, 3'd1, 32'd0, 1'b0);
      complete(1'b0, 1'b0, 32'h304, 3'd1, 32'd0, 32'h000000AB, 2, 0, 2, 1'b0);
      issue(1'b1, 1'b0, 32'h44, 3'd1, 32'd0, 1'b0);
      complete(1'b1, 1'b0, 32'h44, 3'd1, 32'd0, 32'h000000CD, 2, 0, 2, 1'b0);

      // Controller busy for 3 cycles after accept; len 7 clamps to 4
      issue(1'b0, 1'b0, 32'h400, 3'd7, 32'd0, 1'b0);
      complete(1'b0, 1'b0, 32'h400, 3'd7, 32'd0, 32'h89ABCDEF, 2, 3, 0, 1'b0);

      // Zero-length requests
      issue(1'b1, 1'b0, 32'h80, 3'd0, 32'd0, 1'b0);
      complete(1'b1, 1'b0, 32'h80, 3'd0, 32'd0, 32'hFFFFFFFF, 1, 0, 0, 1'b0);
      issue(1'b0, 1'b0, 32'h84, 3'd0, 32'd0, 1'b0);
      complete(1'b0, 1'b0, 32'h84, 3'd0, 32'd0, 32'hFFFFFFFF, 1, 0, 0, 1'b0);

      // Completion pulse while IDLE is ignored
      spur_done = 1'b1;
      @(negedge clk);
      chk("spur_busy", busy, 1'b0);
      @(posedge clk); #1 spur_done = 1'b0;
      @(negedge clk);
      chk("spur_busy_after", busy, 1'b0);
      chk("spur_rvalid", if_rvalid | mem_rvalid, 1'b0);
      @(posedge clk); #1;

      // Random transactions
      repeat (20) begin
         m    = 1'($urandom_range(0, 1));
         we   = 1'($urandom_range(0, 1));
         a    = $urandom;
         l    = 3'($urandom_range(0, 7));
         wd   = $urandom;
         rd   = $urandom;
         lat  = $urandom_range(1, 5);
         bcyc = $urandom_range(0, 2);
         fl   = (!m && l != 3'd0) ? $urandom_range(0, 2) : 0;
         issue(m, we, a, l, wd, 1'b0);
         complete(m, we, a, l, wd, rd, lat, bcyc, fl, 1'b0);
      end

      // Grant order with both stages requesting continuously
      @(posedge clk); #1;
      st0 = start_cnt; ng = 0;
      mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd0; if_req = 1'b1; if_len = 3'd0;
      for (int c = 0; c < 60 && ng < 10; c++) begin
         @(negedge clk);
         if (mem_gnt === 1'b1 && if_gnt === 1'b1) chk("double_gnt", 2'b11, 2'b01);
         if (mem_gnt === 1'b1 || if_gnt === 1'b1) begin
            got_if.push_back(if_gnt);
            ng++;
         end
         @(posedge clk); #1;
      end
      mem_req = 1'b0; if_req = 1'b0;
      chk("grant_count", ng, 10);
      for (int i = 0; i < got_if.size(); i++) begin
`ifdef MEM_ARB_FAIRNESS_EN
         exp_if = ((i % 5) == 4);
`else
         exp_if = 1'b0;
`endif
         chk($sformatf("grant_order[%0d]", i), got_if[i], exp_if);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("order_no_start", start_cnt - st0, 0);

      // Reset while waiting on the controller
      issue(1'b0, 1'b0, 32'h500, 3'd4, 32'd0, 1'b0);
      ctl_lat = 20; ctl_data = 32'h12345678;
      @(posedge clk); #1;
      @(negedge clk);
      chk("wait_busy", busy, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("rstw_busy", busy, 1'b0);
      chk("rstw_if_rvalid", if_rvalid, 1'b0);
      chk("rstw_mem_rvalid", mem_rvalid, 1'b0);
      chk("rstw_ctrl_start", ctrl_start, 1'b0);
      chk("rstw_ctrl_addr", ctrl_addr, 32'd0);
      chk("rstw_rdata", rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rstw_busy_held", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the byte-serial memory controller between the IF stage (instruction fetch) and the MEM stage (load/store). Sits between both pipeline stages and the controller's command port. Latches one request at a time and issues it to the controller with a start pulse. Waits for completion, then returns read data to the owning requester. MEM has fixed priority, bounded by an optional fairness guard so IF cannot starve. IF flush support drops the response of a stale fetch.

Parameters:
ADDR_WIDTH, 32, address width of requests and controller command
STREAK_MAX, 4, consecutive MEM grants allowed while IF is waiting (fairness guard only)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
if_req  in  1  IF request valid
if_addr  in  ADDR_WIDTH  IF fetch address
if_len  in  3  IF byte count
if_gnt  out  1  IF request accepted this cycle (combinational)
if_flush  in  1  kill current or pending IF fetch
if_rvalid  out  1  one-cycle IF response strobe
mem_req  in  1  MEM request valid
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_WIDTH  load/store address
mem_len  in  3  byte count
mem_wdata  in  32  store data, byte 0 in [7:0]
mem_gnt  out  1  MEM request accepted this cycle (combinational)
mem_rvalid  out  1  one-cycle MEM completion strobe (loads and stores)
rdata  out  32  response data, valid with either rvalid
ctrl_start  out  1  one-cycle command strobe to controller
ctrl_we  out  1  command direction
ctrl_addr  out  ADDR_WIDTH  command address
ctrl_len  out  3  command byte count
ctrl_wdata  out  32  command store data
ctrl_busy  in  1  controller busy or in its post-transfer hold cycle
ctrl_done  in  1  one-cycle completion pulse from controller
ctrl_rdata  in  32  controller read data, valid with ctrl_done
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, streak = 0, owner = IF, kill = 0.
  - All outputs 0, except ctrl_* command registers, which hold 0.
  - An in-flight controller transfer is abandoned; the controller shares rst.
- States and transitions:
  - IDLE: a request is accepted per the grant rules below. On accept, latch we/addr/len/wdata/owner and go to ISSUE.
  - ISSUE: hold while ctrl_busy = 1. When ctrl_busy = 0, assert ctrl_start for exactly one cycle and go to WAIT.
  - WAIT: on ctrl_done, register ctrl_rdata into rdata and go to RESP.
  - RESP: assert owner's rvalid for one cycle (suppressed if kill = 1), clear kill, go to IDLE.
- Grant rules (IDLE only; gnt = 0 in all other states):
  - mem_req wins over if_req.
  - if_gnt = if_req & ~if_flush & ~mem_gnt.
  - At most one gnt per cycle.
- Latency: accept at cycle T, ctrl_start at T+1 (ctrl_busy low), rvalid one cycle after ctrl_done. A new accept is possible in the cycle after RESP.
- Length rules:
  - len 1..4 is issued unchanged.
  - len 0: skip ISSUE/WAIT. RESP follows next cycle with rdata = 0; no ctrl_start.
  - len 5..7: clamp to 4.
- Stores: mem_rvalid is pulsed and rdata is cleared to 0.
- Flush:
  - if_flush while owner = IF in ISSUE/WAIT/RESP sets kill. The transaction runs to completion and if_rvalid is suppressed.
  - Flush in RESP suppresses that same cycle's strobe.
  - Flush never affects MEM transactions.
- ctrl_done outside WAIT is ignored.
- ctrl_addr/ctrl_len/ctrl_we/ctrl_wdata stay stable from ISSUE through WAIT.

Optional Feature:
Macro MEM_ARB_FAIRNESS_EN.
- With it:
  - A counter `streak` increments on each MEM grant taken while if_req = 1 and if_flush = 0.
  - It resets to 0 on any IF grant, or when if_req is low in IDLE.
  - When streak == STREAK_MAX and both request, IF is granted instead and streak clears.
- Without it: strict MEM priority, no counter logic.

Test Plan:
- IF only, len 4, addr 0x100; controller returns 0xDEADBEEF 6 cycles after start -> if_gnt at T, ctrl_start at T+1, if_rvalid with rdata = 0xDEADBEEF one cycle after ctrl_done, mem_rvalid stays 0.
- mem_req (store, addr 0x20, len 2, wdata 0x1234) and if_req in the same cycle -> mem_gnt = 1, if_gnt = 0. Then ctrl_we = 1, ctrl_len = 2, mem_rvalid with rdata = 0. IF is granted in the first IDLE cycle afterwards.
- IF fetch in WAIT, pulse if_flush -> transfer completes, if_rvalid never asserts, next MEM load completes normally.
- ctrl_busy held high 3 cycles after accept -> ctrl_start delayed until busy drops, single pulse. len 0 request -> rvalid next cycle, rdata = 0, no ctrl_start.
- MEM_ARB_FAIRNESS_EN, STREAK_MAX = 4, both requesting continuously -> grant order MEM x4, IF, MEM x4, IF. Without the macro -> MEM only. Reset asserted in WAIT -> busy = 0 and all strobes 0 immediately.
